// File: rtl/mod3_rr_scheduler_if.sv
// mod3_rr_scheduler_if
//   Handshake bundle between two word requesters, the shared mod-3 residue
//   engine and the result consumer.
//   req0_* / req1_* : word request channels (valid/ready, WIDTH-bit data)
//   busy            : engine not idle
//   out_*           : held result channel (valid/ready, residue, div3 flag, id)
//   master : requester/consumer side      slave : scheduler side
interface mod3_rr_scheduler_if #(parameter int WIDTH = 8);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic             out_div3;
  logic [1:0]       out_residue;
  logic             out_id;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, out_ready,
    input  req0_ready, req1_ready, busy, out_valid, out_div3, out_residue, out_id
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
    output req0_ready, req1_ready, busy, out_valid, out_div3, out_residue, out_id
  );
endinterface

// File: rtl/mod3_rr_scheduler.sv
// mod3_rr_scheduler
//   Round-robin shares one serial divisible-by-3 engine between two word
//   requesters. An accepted word is shifted MSB-first through a 2-bit residue
//   FSM, one bit per clock; the residue, div3 flag and requester id are then
//   held on the result port until out_ready.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : mod3_rr_scheduler_if.slave (requests, busy, result channel)
module mod3_rr_scheduler #(
  parameter int WIDTH = 8
) (
  input logic                   clk,
  input logic                   reset,
  mod3_rr_scheduler_if.slave    bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [1:0]       r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             prio_q, prio_d;
  logic             id_q, id_d;
  logic             ov_q, ov_d;
  logic             div_q, div_d;
  logic [1:0]       res_q, res_d;
  logic             oid_q, oid_d;

  logic             gnt_id, acc0, acc1, acc, last;
  logic [1:0]       r_nxt;

  // (2r + b) mod 3
  function automatic logic [1:0] r_step(input logic [1:0] r, input logic b);
    case (r)
      2'd0:    r_step = b ? 2'd1 : 2'd0;
      2'd1:    r_step = b ? 2'd0 : 2'd2;
      default: r_step = b ? 2'd2 : 2'd1;
    endcase
  endfunction

  // Contention goes to prio; a lone requester always wins.
  assign gnt_id = (bus.req0_valid & bus.req1_valid) ? prio_q : bus.req1_valid;
  assign acc0   = (state_q == IDLE) & bus.req0_valid & ~gnt_id & ~reset;
  assign acc1   = (state_q == IDLE) & bus.req1_valid &  gnt_id & ~reset;
  assign acc    = acc0 | acc1;
  assign last   = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
  assign r_nxt  = r_step(r_q, sh_q[WIDTH-1]);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc)           state_d = SHIFT;
      SHIFT:   if (last)          state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    bus.req0_ready  = acc0;
    bus.req1_ready  = acc1;
    bus.busy        = (state_q != IDLE);
    bus.out_valid   = ov_q;
    bus.out_div3    = div_q;
    bus.out_residue = res_q;
    bus.out_id      = oid_q;
  end

  // datapath next values
  always_comb begin
    sh_d   = sh_q;
    r_d    = r_q;
    cnt_d  = cnt_q;
    prio_d = prio_q;
    id_d   = id_q;
    ov_d   = ov_q;
    div_d  = div_q;
    res_d  = res_q;
    oid_d  = oid_q;
    if (acc) begin
      sh_d   = acc1 ? bus.req1_data : bus.req0_data;
      r_d    = 2'd0;
      cnt_d  = '0;
      id_d   = acc1;
      prio_d = ~acc1;
    end
    if (state_q == SHIFT) begin
      r_d   = r_nxt;
      sh_d  = {sh_q[WIDTH-2:0], 1'b0};
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        res_d = r_nxt;
        div_d = (r_nxt == 2'd0);
        oid_d = id_q;
        ov_d  = 1'b1;
      end
    end
    if ((state_q == DONE) && bus.out_ready) ov_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q   <= '0;
      r_q    <= 2'd0;
      cnt_q  <= '0;
      prio_q <= 1'b0;
      id_q   <= 1'b0;
      ov_q   <= 1'b0;
      div_q  <= 1'b0;
      res_q  <= 2'd0;
      oid_q  <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      r_q    <= r_d;
      cnt_q  <= cnt_d;
      prio_q <= prio_d;
      id_q   <= id_d;
      ov_q   <= ov_d;
      div_q  <= div_d;
      res_q  <= res_d;
      oid_q  <= oid_d;
    end
  end
endmodule
